// File: rtl/cpu_mem_pkg.sv
// Shared memory-path definitions for the 16-bit CPU store/load units.
// The misalign trap state is only reachable when BYTE_STORE_MISALIGN_TRAP_EN is defined.
package cpu_mem_pkg;

   localparam int BYTE_W = 8;

   localparam logic LANE_LO = 1'b0;
   localparam logic LANE_HI = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_MERGE = 3'd2,
      ST_WRITE = 3'd3,
      ST_ERR   = 3'd4
   } bsu_state_e;

endpackage

// File: rtl/byte_store_unit_if.sv
// Store request and data-RAM bus of byte_store_unit, bundled with master/slave views.
// The misalign flag exists only when BYTE_STORE_MISALIGN_TRAP_EN is defined.
interface byte_store_unit_if #(
   parameter int ADDR_W = 16
) ();

   logic              req;
   logic [ADDR_W-1:0] addr;
   logic [15:0]       wdata;
   logic              byte_mode;
   logic              busy;
   logic              done;
   logic [ADDR_W-2:0] mem_addr;
   logic [15:0]       mem_rdata;
   logic              mem_we;
   logic [15:0]       mem_wdata;
`ifdef BYTE_STORE_MISALIGN_TRAP_EN
   logic              misalign;
`endif

   // Requester side: control FSM plus the RAM returning read data.
   modport master (
      output req, addr, wdata, byte_mode, mem_rdata,
`ifdef BYTE_STORE_MISALIGN_TRAP_EN
      input  misalign,
`endif
      input  busy, done, mem_addr, mem_we, mem_wdata
   );

   // Store unit side.
   modport slave (
      input  req, addr, wdata, byte_mode, mem_rdata,
`ifdef BYTE_STORE_MISALIGN_TRAP_EN
      output misalign,
`endif
      output busy, done, mem_addr, mem_we, mem_wdata
   );

endinterface

// File: rtl/byte_store_unit_byte_lane_merge.sv
// Replaces one byte lane of a 16-bit word; lane 0 is bits [7:0] (little-endian).
module byte_lane_merge
   import cpu_mem_pkg::*;
(
   input  logic [15:0]       old_word,
   input  logic [BYTE_W-1:0] byte_val,
   input  logic              lane,
   output logic [15:0]       merged
);

   // Overwrite the selected lane, keep the neighbouring byte.
   always_comb begin
      merged = old_word;
      if (lane == LANE_HI) begin
         merged[15:8] = byte_val;
      end else begin
         merged[7:0] = byte_val;
      end
   end

endmodule

// File: rtl/byte_store_unit.sv
// Store data path: word stores write directly, byte stores read-modify-write the word.
// Define BYTE_STORE_MISALIGN_TRAP_EN to trap word stores with addr[0]=1 instead of aligning them.
module byte_store_unit
   import cpu_mem_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic            clk,
   input  logic            reset,
   byte_store_unit_if.slave bus
);

   bsu_state_e        state_r;
   bsu_state_e        state_s;
   logic [ADDR_W-2:0] mem_addr_r;
   logic [DATA_W-1:0] mem_wdata_r;
   logic [BYTE_W-1:0] byte_r;
   logic              lane_r;
   logic [DATA_W-1:0] merged_s;
   logic              accept_s;

   assign accept_s = (state_r == ST_IDLE) && bus.req;

   byte_lane_merge u_merge (
      .old_word (bus.mem_rdata),
      .byte_val (byte_r),
      .lane     (lane_r),
      .merged   (merged_s)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.req) begin
               if (bus.byte_mode) begin
                  state_s = ST_READ;
`ifdef BYTE_STORE_MISALIGN_TRAP_EN
               end else if (bus.addr[0]) begin
                  state_s = ST_ERR;
`endif
               end else begin
                  state_s = ST_WRITE;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_READ:  state_s = ST_MERGE;
         ST_MERGE: state_s = ST_WRITE;
         ST_WRITE: state_s = ST_IDLE;
         ST_ERR:   state_s = ST_IDLE;
         default:  state_s = ST_IDLE;
      endcase
   end

   // Request latch and write-data register; mem_addr holds between stores.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_addr_r  <= '0;
         mem_wdata_r <= '0;
         byte_r      <= '0;
         lane_r      <= LANE_LO;
      end else if (accept_s) begin
         mem_addr_r <= bus.addr[ADDR_W-1:1];
         lane_r     <= bus.addr[0];
         byte_r     <= bus.wdata[BYTE_W-1:0];
         if (!bus.byte_mode) begin
            mem_wdata_r <= bus.wdata;
         end else begin
            mem_wdata_r <= mem_wdata_r;
         end
      end else if (state_r == ST_MERGE) begin
         mem_wdata_r <= merged_s;
      end else begin
         mem_wdata_r <= mem_wdata_r;
      end
   end

   // Strobes decode straight from the state register so reset kills them at once.
   assign bus.busy      = (state_r != ST_IDLE);
   assign bus.done      = (state_r == ST_WRITE);
   assign bus.mem_we    = (state_r == ST_WRITE);
   assign bus.mem_addr  = mem_addr_r;
   assign bus.mem_wdata = mem_wdata_r;
`ifdef BYTE_STORE_MISALIGN_TRAP_EN
   assign bus.misalign  = (state_r == ST_ERR);
`endif

endmodule

// File: tb/tb_byte_store_unit.sv
// Scoreboard bench for byte_store_unit: directed cases plus random stores against a shadow memory.
// Honours BYTE_STORE_MISALIGN_TRAP_EN the same way as the design.
module tb_byte_store_unit;

   logic clk;
   logic reset;
   int   cyc;
   int   n_checks;
   int   n_fail;

   typedef struct {
      logic [14:0] waddr;
      logic [15:0] data;
      int          cyc;
      bit          trap;
   } exp_t;

   exp_t        q[$];
   logic [15:0] ram    [0:32767];
   logic [15:0] shadow [0:32767];

   byte_store_unit_if #(.ADDR_W(16)) bus ();

   byte_store_unit #(.ADDR_W(16), .DATA_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous single-port RAM, read data one cycle after address.
   always @(posedge clk) begin
      if (bus.mem_we === 1'b1) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp_v, $time);
      end
   endtask

   function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] d, input bit bm);
      logic [15:0] old;
      old = shadow[a[15:1]];
      if (!bm) return d;
      if (a[0]) return {d[7:0], old[7:0]};
      return {old[15:8], d[7:0]};
   endfunction

   // Monitor: every write (or trap) must match the head of the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (reset === 1'b0) begin
         if (bus.mem_we === 1'b1) begin
            if (q.size() == 0 || q[0].trap) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_write actual=addr %h data %h required=no write",
                        bus.mem_addr, bus.mem_wdata);
            end else begin
               e = q.pop_front();
               chk("write_addr",  {17'd0, bus.mem_addr}, {17'd0, e.waddr});
               chk("write_data",  {16'd0, bus.mem_wdata}, {16'd0, e.data});
               chk("write_cycle", cyc, e.cyc);
               chk("write_done",  {31'd0, bus.done}, 32'd1);
               chk("write_busy",  {31'd0, bus.busy}, 32'd1);
               shadow[e.waddr] = e.data;
            end
         end else if (bus.done === 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL done_without_write actual=done 1 required=done 0");
         end
`ifdef BYTE_STORE_MISALIGN_TRAP_EN
         if (bus.misalign === 1'b1) begin
            if (q.size() == 0 || !q[0].trap) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_misalign actual=1 required=0");
            end else begin
               e = q.pop_front();
               chk("trap_cycle", cyc, e.cyc);
               chk("trap_no_we", {31'd0, bus.mem_we}, 32'd0);
               chk("trap_busy",  {31'd0, bus.busy}, 32'd1);
            end
         end
`endif
      end
   end

   // Waits for idle, pushes the expected result and drives a one-cycle request at cycle T.
   task automatic issue(input logic [15:0] a, input logic [15:0] d, input bit bm);
      exp_t e;
      int   guard;
      guard = 0;
      @(negedge clk);
      while (bus.busy !== 1'b0 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20) begin
         n_checks++; n_fail++;
         $display("FAIL busy_wait actual=busy required=idle");
      end
      e.waddr = a[15:1];
      e.data  = model(a, d, bm);
      e.cyc   = cyc + (bm ? 3 : 1);
      e.trap  = 1'b0;
`ifdef BYTE_STORE_MISALIGN_TRAP_EN
      if (!bm && a[0]) e.trap = 1'b1;
`endif
      q.push_back(e);
      bus.req = 1'b1; bus.addr = a; bus.wdata = d; bus.byte_mode = bm;
      @(negedge clk);
      bus.req = 1'b0;
   endtask

   initial begin
      int c0;
      int guard;
      n_checks = 0; n_fail = 0; cyc = 0;
      bus.req = 1'b0; bus.addr = 16'h0000; bus.wdata = 16'h0000; bus.byte_mode = 1'b0;
      for (int i = 0; i < 32; i++) begin
         ram[i] = 16'($urandom);
         shadow[i] = ram[i];
      end
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy",      {31'd0, bus.busy}, 32'd0);
      chk("rst_done",      {31'd0, bus.done}, 32'd0);
      chk("rst_we",        {31'd0, bus.mem_we}, 32'd0);
      chk("rst_mem_addr",  {17'd0, bus.mem_addr}, 32'd0);
      chk("rst_mem_wdata", {16'd0, bus.mem_wdata}, 32'd0);
`ifdef BYTE_STORE_MISALIGN_TRAP_EN
      chk("rst_misalign",  {31'd0, bus.misalign}, 32'd0);
`endif
      reset = 1'b0;

      // Word store, then busy must be low at T+2.
      issue(16'h0010, 16'hBEEF, 1'b0);
      @(negedge clk);
      chk("word_busy_t2", {31'd0, bus.busy}, 32'd0);

      // Byte store low lane; a competing req during READ/MERGE must be ignored.
      ram[8] = 16'h1234; shadow[8] = 16'h1234;
      issue(16'h0010, 16'hFFAB, 1'b1);
      chk("read_addr", {17'd0, bus.mem_addr}, 32'h8);
      chk("read_we",   {31'd0, bus.mem_we}, 32'd0);
      bus.req = 1'b1; bus.addr = 16'h0030; bus.wdata = 16'h5555; bus.byte_mode = 1'b0;
      @(negedge clk);
      @(negedge clk);
      bus.req = 1'b0;
      @(negedge clk);
      chk("low_lane_ram", {16'd0, ram[8]}, 32'h12AB);

      // Byte store high lane.
      ram[8] = 16'h1234; shadow[8] = 16'h1234;
      issue(16'h0011, 16'h00CD, 1'b1);
      repeat (3) @(negedge clk);
      chk("high_lane_ram", {16'd0, ram[8]}, 32'hCD34);

      // Reset in the READ cycle of a byte store aborts it.
      issue(16'h0010, 16'h0077, 1'b1);
      reset = 1'b1;
      #1;
      chk("abort_we",   {31'd0, bus.mem_we}, 32'd0);
      chk("abort_busy", {31'd0, bus.busy}, 32'd0);
      void'(q.pop_back());
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_ram", {16'd0, ram[8]}, {16'd0, shadow[8]});
      issue(16'h0012, 16'hA5A5, 1'b0);

      // req held high for 8 cycles: only every other word store is accepted.
      guard = 0;
      @(negedge clk);
      while (bus.busy !== 1'b0 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      for (int k = 0; k < 8; k++) begin
         exp_t e;
         logic [15:0] a;
         logic [15:0] d;
         a = 16'h0020 + 16'(2 * k);
         d = 16'($urandom);
         c0 = cyc;
         if (k % 2 == 0) begin
            e.waddr = a[15:1]; e.data = d; e.cyc = c0 + 1; e.trap = 1'b0;
            q.push_back(e);
         end
         bus.req = 1'b1; bus.addr = a; bus.wdata = d; bus.byte_mode = 1'b0;
         @(negedge clk);
      end
      bus.req = 1'b0;

      // Misaligned word store.
      issue(16'h0011, 16'h4321, 1'b0);

      // Random stores in a small window so bytes and words interact.
      for (int i = 0; i < 40; i++) begin
         issue(16'($urandom_range(0, 63)), 16'($urandom), bit'($urandom_range(0, 1)));
      end

      guard = 0;
      while (q.size() != 0 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (q.size() != 0) begin
         n_checks++; n_fail++;
         $display("FAIL drain_timeout actual=%0d pending required=0", q.size());
      end
      repeat (2) @(negedge clk);
      for (int i = 0; i < 32; i++) begin
         chk("final_ram", {16'd0, ram[i]}, {16'd0, shadow[i]});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
